// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared by the instruction word loader,
// its encoder and anything that builds instruction field sets.
//   fmt_e    - instruction format codes carried on the 3-bit fmt field
//   OP_*     - RV32I major opcodes
//   state_e  - loader session states
//   fields_t - one decoded field set as presented to the encoder
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_B    = 7'h63;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_JAL  = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // fmt is kept as raw bits so the illegal codes 6 and 7 remain representable.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/instr_word_loader_if.sv
// instr_word_loader_if: field-set handshake plus instruction memory write port.
//   in_valid/in_ready/in_last - beat handshake from the front end
//   fmt..imm                  - decoded instruction fields of the beat
//   mem_we/mem_addr/mem_wdata - registered memory write port
// Modports: master = front end (drives beats, observes writes),
//           slave  = loader.
interface instr_word_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_last, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: purely combinational RV32I packer.
//   f       in  decoded field set (fmt selects the layout)
//   word    out encoded 32-bit instruction
//   illegal out fmt is not one of R/I/S/B/U/J; word is zero in that case
module instr_encoder
  import riscv_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        illegal
);

  // NOTE: every output gets a default before the case so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (f.fmt)
      FMT_R: word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I: word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S: word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B: word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                     f.imm[4:1], f.imm[11], f.opcode};
      FMT_U: word = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                     f.rd, f.opcode};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_word_loader.sv
// instr_word_loader: accepts decoded field sets, encodes them and writes the
// words sequentially into instruction memory from address 0.
//   clk    in  clock, all state on the rising edge
//   reset  in  synchronous active-high reset
//   start  in  opens a load session from IDLE or DONE
//   bus    slave side of instr_word_loader_if (beats in, memory writes out)
//   count  out words written this session (doubles as the write pointer)
//   done   out session finished
//   full   out session ended because DEPTH words were written
//   err    out sticky: an illegal fmt was received this session
module instr_word_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  instr_word_loader_if.slave   bus,
  output logic [ADDR_W:0]      count,
  output logic                 done,
  output logic                 full,
  output logic                 err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  fields_t           fields;
  logic [31:0]       word;
  logic              illegal;
  logic              in_ready;
  logic              accept;
  logic [ADDR_W:0]   count_inc;

  assign fields = '{fmt:    bus.fmt,
                    opcode: bus.opcode,
                    rd:     bus.rd,
                    funct3: bus.funct3,
                    rs1:    bus.rs1,
                    rs2:    bus.rs2,
                    funct7: bus.funct7,
                    imm:    bus.imm};

  instr_encoder u_encoder (
    .f       (fields),
    .word    (word),
    .illegal (illegal)
  );

  // count is the write pointer, so ready falls as soon as the last slot is
  // taken; there is never a beat DEPTH+1 and no wrap-around.
  assign in_ready  = (state_q == ST_LOAD) && (count_q < DEPTH_C);
  assign accept    = bus.in_valid && in_ready;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    full_d      = full_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
          full_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // Illegal beats complete the handshake but leave memory and the
          // pointer untouched.
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = count_q[ADDR_W-1:0];
            mem_wdata_d = word;
            count_d     = count_inc;
            if (count_inc == DEPTH_C) begin
              full_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
          if (bus.in_last) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count         = count_q;
  assign done          = (state_q == ST_DONE);
  assign full          = full_q;
  assign err           = err_q;

endmodule

// File: tb/tb_instr_word_loader.sv
// Bench for instr_word_loader: a 256-deep instance driven from a vector table
// plus hand-written sequences, and a 4-deep instance for the full condition.
module tb_instr_word_loader;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b;
  logic [8:0] count_a;
  logic [2:0] count_b;
  logic done_a, full_a, err_a;
  logic done_b, full_b, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_word_loader_if #(.ADDR_W(8)) bus_a ();
  instr_word_loader_if #(.ADDR_W(2)) bus_b ();

  instr_word_loader #(.DEPTH(256)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .count(count_a), .done(done_a), .full(full_a), .err(err_a)
  );

  instr_word_loader #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .count(count_b), .done(done_b), .full(full_b), .err(err_b)
  );

  typedef struct {
    logic        start;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        last;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [8:0]  exp_count;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.fmt    = v.fmt;
    bus_a.opcode = v.opcode;
    bus_a.rd     = v.rd;
    bus_a.funct3 = v.f3;
    bus_a.rs1    = v.rs1;
    bus_a.rs2    = v.rs2;
    bus_a.funct7 = v.f7;
    bus_a.imm    = v.imm;
    bus_a.in_last  = v.last;
    bus_a.in_valid = 1'b1;
  endtask

  // addi x<r>,x0,<r> on the small instance.
  task automatic drive_b_addi(input int r);
    bus_b.fmt    = FMT_I;
    bus_b.opcode = OP_I;
    bus_b.rd     = 5'(r);
    bus_b.funct3 = 3'd0;
    bus_b.rs1    = 5'd0;
    bus_b.rs2    = 5'd0;
    bus_b.funct7 = 7'd0;
    bus_b.imm    = 32'(r);
    bus_b.in_last  = 1'b0;
    bus_b.in_valid = 1'b1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " in_ready"},  bus_a.in_ready,  0);
    check({tag, " mem_we"},    bus_a.mem_we,    0);
    check({tag, " mem_addr"},  bus_a.mem_addr,  0);
    check({tag, " mem_wdata"}, bus_a.mem_wdata, 0);
    check({tag, " count"},     count_a,         0);
    check({tag, " done"},      done_a,          0);
    check({tag, " full"},      full_a,          0);
    check({tag, " err"},       err_a,           0);
  endtask

  initial begin
    int writes;
    logic [1:0]  last_addr;
    logic [31:0] last_wdata;

    // start, fmt, opcode, rd, f3, rs1, rs2, f7, imm, last | we, addr, wdata, count, done, err
    // Session 1: add x3,x1,x2 as a single last beat.
    vecs[0] = '{1'b1, FMT_R, OP_R, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b1,
                1'b1, 8'd0, 32'h002081B3, 9'd1, 1'b1, 1'b0};
    // Session 2: addi (unused rs2/f7 junk), illegal fmt 7 and 6, then sw last.
    vecs[1] = '{1'b1, FMT_I, OP_I, 5'd5, 3'd0, 5'd0, 5'd31, 7'h7F, 32'h0000_0FFF, 1'b0,
                1'b1, 8'd0, 32'hFFF00293, 9'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd7, OP_R, 5'd9, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b0,
                1'b0, 8'd0, 32'hFFF00293, 9'd1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 3'd6, OP_I, 5'd9, 3'd1, 5'd1, 5'd2, 7'd0, 32'd4, 1'b0,
                1'b0, 8'd0, 32'hFFF00293, 9'd1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, FMT_S, OP_S, 5'd31, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b1,
                1'b1, 8'd1, 32'h0020A423, 9'd2, 1'b1, 1'b1};
    // Session 3: restart from DONE, back-to-back stream at addrs 0..4.
    vecs[5] = '{1'b1, FMT_I, OP_I, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0FFF, 1'b0,
                1'b1, 8'd0, 32'hFFF00293, 9'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, FMT_S, OP_S, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0,
                1'b1, 8'd1, 32'h0020A423, 9'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b0, FMT_B, OP_B, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd17, 1'b0,
                1'b1, 8'd2, 32'h00208863, 9'd3, 1'b0, 1'b0};
    vecs[8] = '{1'b0, FMT_U, OP_LUI, 5'd7, 3'd7, 5'd31, 5'd0, 7'd0, 32'h1234_5000, 1'b0,
                1'b1, 8'd3, 32'h123453B7, 9'd4, 1'b0, 1'b0};
    vecs[9] = '{1'b0, FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800, 1'b1,
                1'b1, 8'd4, 32'h001000EF, 9'd5, 1'b1, 1'b0};

    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    drive_a(vecs[0]);
    bus_a.in_valid = 1'b0;
    drive_b_addi(0);
    bus_b.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].start) begin
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check($sformatf("v%0d start count", i), count_a, 0);
        check($sformatf("v%0d start err", i),   err_a,   0);
        check($sformatf("v%0d start full", i),  full_a,  0);
        check($sformatf("v%0d start done", i),  done_a,  0);
      end
      @(negedge clk);
      drive_a(vecs[i]);
      #1;
      check($sformatf("v%0d in_ready", i), bus_a.in_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d mem_we", i),    bus_a.mem_we,    vecs[i].exp_we);
      check($sformatf("v%0d mem_addr", i),  bus_a.mem_addr,  vecs[i].exp_addr);
      check($sformatf("v%0d mem_wdata", i), bus_a.mem_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d count", i),     count_a,         vecs[i].exp_count);
      check($sformatf("v%0d done", i),      done_a,          vecs[i].exp_done);
      check($sformatf("v%0d err", i),       err_a,           vecs[i].exp_err);
    end

    // DONE holds: no further write, address/data hold, ready low.
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("done hold mem_we",    bus_a.mem_we,    0);
    check("done hold mem_addr",  bus_a.mem_addr,  4);
    check("done hold mem_wdata", bus_a.mem_wdata, 32'h001000EF);
    check("done hold done",      done_a,          1);
    check("done hold count",     count_a,         5);
    check("done hold in_ready",  bus_a.in_ready,  0);

    // start during LOAD is ignored: the pointer keeps advancing.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drive_a(vecs[5]);
    @(posedge clk);
    #1;
    check("load start1 count", count_a, 1);
    @(negedge clk);
    start_a = 1'b1;
    drive_a(vecs[6]);
    @(posedge clk);
    #1;
    check("load start2 count",    count_a,        2);
    check("load start2 mem_addr", bus_a.mem_addr, 1);

    // Reset in the cycle after an accepted beat.
    @(negedge clk);
    start_a = 1'b0;
    drive_a(vecs[7]);
    @(negedge clk);
    check("pre-reset mem_we", bus_a.mem_we, 1);
    bus_a.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_a("reset after beat");

    // Reset on the same edge as an acceptance drops the pending write;
    // start on that edge loses to reset.
    @(negedge clk);
    reset = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drive_a(vecs[8]);
    reset = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    check_reset_a("reset with beat");
    @(negedge clk);
    reset = 1'b0;
    start_a = 1'b0;
    bus_a.in_valid = 1'b0;
    #1;
    check("reset start idle in_ready", bus_a.in_ready, 0);

    // DEPTH=4 instance: six beats offered, exactly four written.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    writes = 0;
    last_addr = '0;
    last_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_b_addi(i);
      #1;
      check($sformatf("b%0d in_ready", i), bus_b.in_ready, (i < 4) ? 1 : 0);
      @(posedge clk);
      #1;
      if (bus_b.mem_we) begin
        writes++;
        last_addr = bus_b.mem_addr;
        last_wdata = bus_b.mem_wdata;
      end
      check($sformatf("b%0d mem_we", i), bus_b.mem_we, (i < 4) ? 1 : 0);
    end
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    check("b writes",     writes,     4);
    check("b last addr",  last_addr,  3);
    check("b last wdata", last_wdata, 32'h00300193);
    check("b full",       full_b,     1);
    check("b done",       done_b,     1);
    check("b count",      count_b,    4);

    // Illegal beat with in_last still ends the session, without a write.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    drive_b_addi(0);
    bus_b.fmt = 3'd6;
    bus_b.in_last = 1'b1;
    @(posedge clk);
    #1;
    check("b illegal last done",   done_b,       1);
    check("b illegal last err",    err_b,        1);
    check("b illegal last count",  count_b,      0);
    check("b illegal last mem_we", bus_b.mem_we, 0);
    check("b illegal last full",   full_b,       0);
    @(negedge clk);
    bus_b.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
